// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the sync ROM address, and holds the IF/ID pipeline register.
// Latency: one cycle fetch-to-decode; a redirect gives one bubble, then the target on the following edge.
// Backpressure: stall holds the PC and IF/ID; a redirect overrides stall. FETCH_PERF_EN adds perf counters.
module fetch_stage #(
    parameter int IMEM_AW = 12
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               jump_en,
    input  logic [26:0]        jump_target,
    input  logic               ex_redirect_en,
    input  logic [31:0]        ex_redirect_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_q,
    output logic [31:0]        ifid_instr,
    output logic [31:0]        ifid_pc1,
    output logic               ifid_valid,
    output logic [31:0]        pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushes
`endif
);

    logic [31:0] next_pc;
    logic [31:0] pc_plus1;
    logic        flush;

    assign pc_plus1 = pc + 32'd1;

    // Either redirect discards the instruction currently being fetched.
    assign flush = ex_redirect_en | jump_en;

    // Next-PC priority: execute redirect is older than a decode jump, so it wins;
    // held at 0 during reset so the ROM already sees address 0 on release.
    always_comb begin
        next_pc = pc_plus1;
        if (!reset_n) begin
            next_pc = 32'd0;
        end else if (ex_redirect_en) begin
            next_pc = ex_redirect_target;
        end else if (jump_en) begin
            next_pc = {5'b0, jump_target};
        end else if (stall) begin
            next_pc = pc;
        end
    end

    // The ROM registers this on the same edge that pc loads next_pc, so imem_q tracks pc.
    assign imem_addr = next_pc[IMEM_AW-1:0];

    // Program counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= 32'd0;
        end else begin
            pc <= next_pc;
        end
    end

    // IF/ID register: flush inserts a nop bubble, stall holds, otherwise load the fetched word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ifid_instr <= 32'd0;
            ifid_pc1   <= 32'd0;
            ifid_valid <= 1'b0;
        end else if (flush) begin
            ifid_instr <= 32'd0;
            ifid_pc1   <= 32'd0;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_instr <= imem_q;
            ifid_pc1   <= pc_plus1;
            ifid_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    // Count valid IF/ID loads and flush events; both wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= 32'd0;
            perf_flushes <= 32'd0;
        end else begin
            if (flush) begin
                perf_flushes <= perf_flushes + 32'd1;
            end else if (!stall) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
        end
    end
`endif

endmodule
